// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one I2C master among C_NUM_REQ requesters; ARB_WATCHDOG_EN adds a hold-time watchdog
module i2c_bus_arbiter #(
  parameter int C_NUM_REQ      = 2,
  parameter int C_RELEASE_IDLE = 4,
  parameter int C_MAX_HOLD     = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [C_NUM_REQ-1:0]     req_en,
  input  logic [C_NUM_REQ-1:0]     req_lock,
  input  logic [7*C_NUM_REQ-1:0]   req_addr,
  input  logic [C_NUM_REQ-1:0]     req_write,
  input  logic [8*C_NUM_REQ-1:0]   req_wdata,
  input  logic [C_NUM_REQ-1:0]     req_multibyte_n,
  output logic [7:0]               req_rdata,
  output logic [C_NUM_REQ-1:0]     req_act,
  output logic [C_NUM_REQ-1:0]     req_err,
  output logic [C_NUM_REQ-1:0]     req_next,
  output logic [C_NUM_REQ-1:0]     gnt,
  output logic                     busy,
  output logic                     watchdog_irq,
  output logic                     m_en,
  output logic                     m_write,
  output logic                     m_multibyte_n,
  output logic [6:0]               m_addr,
  output logic [7:0]               m_wdata,
  input  logic [7:0]               m_rdata,
  input  logic                     m_act,
  input  logic                     m_err,
  input  logic                     m_next
);
  localparam int IW  = $clog2(C_NUM_REQ);
  localparam int IDW = $clog2(C_RELEASE_IDLE + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t               state, state_d;
  logic [C_NUM_REQ-1:0] gnt_d;
  logic [IW-1:0]        rr_ptr, rr_d, sel, pick, cand;
  logic [IDW-1:0]       idle_cnt, idle_d;
  logic                 quiet, rel, wd_rel, irq_d;
  if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || C_RELEASE_IDLE < 1 || C_RELEASE_IDLE > 255 || C_MAX_HOLD < 1)
    begin : g_bad_param
      $error("i2c_bus_arbiter: parameter out of range");
    end
`ifdef ARB_WATCHDOG_EN
  localparam int HW = $clog2(C_MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt, hold_d;
  assign wd_rel = hold_cnt >= HW'(C_MAX_HOLD) && !m_act;
  assign hold_d = state == GRANT ? (&hold_cnt ? hold_cnt : hold_cnt + 1'b1) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_cnt <= '0;
    else hold_cnt <= state_d == IDLE ? '0 : hold_d;
`else
  assign wd_rel = 1'b0;
`endif
  assign busy      = state == GRANT;
  assign req_rdata = m_rdata;
  assign req_act   = busy ? (~gnt | (gnt & {C_NUM_REQ{m_act}})) : {C_NUM_REQ{m_act}};
  assign req_err   = gnt & {C_NUM_REQ{m_err}};
  assign req_next  = gnt & {C_NUM_REQ{m_next}};
  assign m_en          = |(gnt & req_en);
  assign m_write       = |(gnt & req_write);
  assign m_multibyte_n = |(gnt & req_multibyte_n);
  // Owner keeps the bus while it is requesting, locking, or the master is still active.
  assign quiet = !m_en && !m_act && !(|(gnt & req_lock));
  assign rel   = (quiet && idle_cnt == IDW'(C_RELEASE_IDLE - 1)) || wd_rel;
  always_comb begin
    sel     = '0;
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < C_NUM_REQ; i++)
      if (gnt[i]) begin
        sel     = IW'(i);
        m_addr  = req_addr[7*i +: 7];
        m_wdata = req_wdata[8*i +: 8];
      end
  end
  // Descending offsets so the nearest requester at or after rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int j = C_NUM_REQ - 1; j >= 0; j--) begin
      cand = IW'((int'(rr_ptr) + j) % C_NUM_REQ);
      if (req_en[cand]) pick = cand;
    end
  end
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    rr_d    = rr_ptr;
    idle_d  = '0;
    irq_d   = 1'b0;
    if (state == IDLE) begin
      if (|req_en && !m_act) begin
        state_d = GRANT;
        gnt_d   = {{(C_NUM_REQ-1){1'b0}}, 1'b1} << pick;
      end
    end else begin
      idle_d = quiet ? idle_cnt + 1'b1 : '0;
      if (rel) begin
        state_d = IDLE;
        gnt_d   = '0;
        idle_d  = '0;
        rr_d    = sel == IW'(C_NUM_REQ - 1) ? '0 : sel + 1'b1;
        irq_d   = wd_rel;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      gnt          <= '0;
      rr_ptr       <= '0;
      idle_cnt     <= '0;
      watchdog_irq <= 1'b0;
    end else begin
      state        <= state_d;
      gnt          <= gnt_d;
      rr_ptr       <= rr_d;
      idle_cnt     <= idle_d;
      watchdog_irq <= irq_d;
    end
endmodule
